// File: rtl/spi_sample_receiver.sv
// -----------------------------------------------------------------------------
// spi_sample_receiver
//
// SPI master front end for the clap-clap light datapath. Drives spi_clock and
// spi_chipselect toward the off-board ADC. Shifts in one SAMPLE_WIDTH-bit word
// per frame, MSB first, and hands each finished word to the clap detector.
//
// Frame: IDLE (GAP_CYCLES, cs high) -> SETUP (cs low, sclk high) ->
// SAMPLE_WIDTH x (LOW, HIGH) -> HOLD -> IDLE. Every phase after IDLE lasts
// CLOCK_DIV cycles, so the frame period is GAP_CYCLES + CLOCK_DIV*(2*SAMPLE_WIDTH+2).
//
// Ports:
//   inclock        system clock, everything on the rising edge
//   reset          asynchronous, active-high reset
//   enable         permission to start a frame (looked at only in IDLE)
//   spi_clock      SPI clock toward the ADC, idles high
//   spi_chipselect active-low chip select toward the ADC
//   spi_data       serial data from the ADC (changes on spi_clock fall)
//   sample_data    last captured word
//   sample_valid   sample_data holds a word not yet consumed
//   sample_ready   consumer accepts the word
//   overrun        one-cycle pulse: an unconsumed word was overwritten
//   fsm_state      current frame state, for observation only
//
// Handshake: a word is consumed on any clock edge where sample_valid and
// sample_ready are both high. sample_data does not change while sample_valid
// is high and the word is unconsumed, except when a new word is loaded. The
// SPI side never waits for the consumer. A load in the same cycle as a consume
// keeps sample_valid high without an overrun. A load with no consume
// overwrites the word and raises overrun alongside the new word.
//
// Build option: define SPI_SAMPLE_SIGNED_EN to convert the ADC's offset-binary
// word to two's complement (MSB inverted) when it is loaded into sample_data.
// -----------------------------------------------------------------------------
module spi_sample_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CLOCK_DIV    = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                    inclock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    spi_clock,
  output logic                    spi_chipselect,
  input  logic                    spi_data,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  output logic [2:0]              fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int DIV_W = $clog2(CLOCK_DIV);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BIT_W = $clog2(SAMPLE_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q;
  logic [GAP_W-1:0]        gap_q;
  logic [BIT_W-1:0]        bit_q;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [1:0]              sync_q;
  logic [SAMPLE_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    sclk_q;
  logic                    cs_q;

  logic                    div_last;
  logic                    gap_done;
  logic                    shift_en;
  logic                    load;
  logic                    consume;
  logic [SAMPLE_WIDTH-1:0] load_word;

  assign div_last = (div_q == DIV_LAST);
  // gap_q stops at GAP_LAST, so with enable low it stays "done" and the
  // next frame starts on the first cycle enable returns.
  assign gap_done = (gap_q == GAP_LAST);
  assign shift_en = (state_q == ST_HIGH) && div_last;
  assign load     = (state_q == ST_HOLD) && div_last;
  assign consume  = valid_q && sample_ready;

`ifdef SPI_SAMPLE_SIGNED_EN
  assign load_word = {~shift_q[SAMPLE_WIDTH-1], shift_q[SAMPLE_WIDTH-2:0]};
`else
  assign load_word = shift_q;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gap_done && enable) state_d = ST_SETUP;
      ST_SETUP: if (div_last) state_d = ST_LOW;
      ST_LOW:   if (div_last) state_d = ST_HIGH;
      ST_HIGH:  if (div_last) state_d = (bit_q == BIT_LAST) ? ST_HOLD : ST_LOW;
      ST_HOLD:  if (div_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      sync_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], spi_data};

      // Every non-idle phase is exactly CLOCK_DIV cycles, so wrapping at
      // div_last is the same as restarting on each phase change.
      if (state_q == ST_IDLE || div_last) div_q <= '0;
      else                                div_q <= div_q + DIV_W'(1);

      if (state_q == ST_IDLE) begin
        if (!gap_done) gap_q <= gap_q + GAP_W'(1);
      end else if (load) begin
        gap_q <= '0;
      end

      if (shift_en) begin
        shift_q <= {shift_q[SAMPLE_WIDTH-2:0], sync_q[1]};
        bit_q   <= bit_q + BIT_W'(1);
      end else if (load) begin
        bit_q   <= '0;
      end

      if (load) data_q <= load_word;

      if (load)         valid_q <= 1'b1;
      else if (consume) valid_q <= 1'b0;

      overrun_q <= load && valid_q && !sample_ready;

      // Pins are registered from the next state so they carry no decode glitches.
      sclk_q <= (state_d != ST_LOW);
      cs_q   <= (state_d == ST_IDLE);
    end
  end

  assign spi_clock      = sclk_q;
  assign spi_chipselect = cs_q;
  assign sample_data    = data_q;
  assign sample_valid   = valid_q;
  assign overrun        = overrun_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_spi_sample_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_sample_receiver
//
// Directed sequence with randomized words for spi_sample_receiver. A small
// ADC model serves words MSB first on spi_clock falling edges and records the
// expected delivered word in exp_q. Timing expectations come from the frame
// arithmetic: chip select falls GAP cycles after idle begins, and the word
// loads CLOCK_DIV*(2*W+2) cycles after that.
// -----------------------------------------------------------------------------
module tb_spi_sample_receiver;

  localparam int W           = 16;
  localparam int CD          = 4;
  localparam int GAP         = 8;
  localparam int LOAD_OFFSET = CD * (2 * W + 2);
  localparam int PERIOD      = GAP + LOAD_OFFSET;
`ifdef SPI_SAMPLE_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         inclock      = 1'b0;
  logic         reset        = 1'b0;
  logic         enable       = 1'b0;
  logic         spi_data     = 1'b0;
  logic         sample_ready = 1'b0;
  logic         spi_clock;
  logic         spi_chipselect;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         overrun;
  logic [2:0]   fsm_state;

  int cyc        = 0;
  int errors     = 0;
  int checks     = 0;
  int sclk_falls = 0;
  int ovr_pulses = 0;
  int adc_idx    = -1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] adc_q[$];
  logic [W-1:0] adc_word = '0;

  always #5 inclock = ~inclock;
  always @(posedge inclock) cyc <= cyc + 1;

  spi_sample_receiver #(
    .SAMPLE_WIDTH (W),
    .CLOCK_DIV    (CD),
    .GAP_CYCLES   (GAP)
  ) dut (
    .inclock        (inclock),
    .reset          (reset),
    .enable         (enable),
    .spi_clock      (spi_clock),
    .spi_chipselect (spi_chipselect),
    .spi_data       (spi_data),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .overrun        (overrun),
    .fsm_state      (fsm_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_word(input logic [W-1:0] raw);
    logic [W-1:0] msb;
    msb        = '0;
    msb[W-1]   = 1'b1;
    return SIGNED_BUILD ? (raw ^ msb) : raw;
  endfunction

  // ADC: new word at each chip-select fall, one bit per spi_clock fall.
  always @(negedge spi_chipselect) begin
    if (adc_q.size() > 0) adc_word = adc_q.pop_front();
    else                  adc_word = W'($urandom);
    exp_q.push_back(model_word(adc_word));
    adc_idx    = W - 1;
    sclk_falls = 0;
  end

  always @(negedge spi_clock) begin
    if (spi_chipselect === 1'b0) begin
      sclk_falls++;
      if (adc_idx >= 0) begin
        spi_data = adc_word[adc_idx];
        adc_idx--;
      end
    end
  end

  always @(negedge inclock) if (overrun === 1'b1) ovr_pulses++;

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge inclock);
      #1;
    end
  endtask

  task automatic wait_cs_fall(input string tag, output int at);
    int n;
    n = 0;
    while (spi_chipselect !== 1'b0 && n < 3 * PERIOD) begin
      tick(1);
      n++;
    end
    check({tag, "_cs_fall"}, spi_chipselect, 1'b0);
    at = cyc;
  endtask

  task automatic finish_frame(input string tag, input int cs_at, input bit want_ovr,
                              input bit ready_at_load);
    logic [W-1:0] want;
    if (cs_at + LOAD_OFFSET - 1 > cyc) tick(cs_at + LOAD_OFFSET - 1 - cyc);
    check({tag, "_cs_low_hold"}, spi_chipselect, 1'b0);
    if (ready_at_load) sample_ready = 1'b1;
    tick(1);
    check({tag, "_exp_avail"}, (exp_q.size() > 0), 1'b1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, sample_data, want);
    check({tag, "_valid"}, sample_valid, 1'b1);
    check({tag, "_overrun"}, overrun, want_ovr);
    check({tag, "_cs_idle"}, spi_chipselect, 1'b1);
    check({tag, "_sclk_falls"}, sclk_falls, W);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rel, prev, at, en_at, lows;
    logic [W-1:0] fixed_words[3];

    adc_q.push_back(16'hA5C3);
    adc_q.push_back(16'h0000);
    adc_q.push_back(16'hFFFF);
    adc_q.push_back(16'h8001);
    adc_q.push_back(16'h1234);
    adc_q.push_back(16'h5678);
    adc_q.push_back(W'($urandom));
    adc_q.push_back(16'h8000);
    adc_q.push_back(16'h7FFF);
    for (int i = 0; i < 4; i++) adc_q.push_back(W'($urandom));

    #1 reset = 1'b1;
    tick(3);
    check("rst_sclk", spi_clock, 1'b1);
    check("rst_cs", spi_chipselect, 1'b1);
    check("rst_data", sample_data, '0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // First frame straight out of reset
    enable       = 1'b1;
    sample_ready = 1'b1;
    reset        = 1'b0;
    rel          = cyc;
    wait_cs_fall("f_a5c3", at);
    check("first_cs_cycle", at - rel, GAP);
    finish_frame("w_a5c3", at, 1'b0, 1'b0);
    tick(1);
    check("w_a5c3_consumed", sample_valid, 1'b0);
    prev = at;

    // Back-to-back frames with the consumer always ready
    fixed_words = '{16'h0000, 16'hFFFF, 16'h8001};
    for (int i = 0; i < 3; i++) begin
      wait_cs_fall($sformatf("f_rdy%0d", i), at);
      check($sformatf("period_rdy%0d", i), at - prev, PERIOD);
      finish_frame($sformatf("w_%04h", fixed_words[i]), at, 1'b0, 1'b0);
      tick(1);
      check($sformatf("rdy%0d_one_cycle_valid", i), sample_valid, 1'b0);
      prev = at;
    end
    check("no_overrun_when_ready", ovr_pulses, 0);

    // Consumer stalls across two frames
    sample_ready = 1'b0;
    wait_cs_fall("f_1234", at);
    finish_frame("w_1234", at, 1'b0, 1'b0);
    tick(1);
    check("w_1234_held", sample_valid, 1'b1);
    wait_cs_fall("f_5678", at);
    tick(100);
    check("stable_data", sample_data, model_word(16'h1234));
    check("stable_valid", sample_valid, 1'b1);
    finish_frame("w_5678", at, 1'b1, 1'b0);
    tick(1);
    check("overrun_one_cycle", overrun, 1'b0);
    check("w_5678_held_valid", sample_valid, 1'b1);
    check("w_5678_held_data", sample_data, model_word(16'h5678));
    check("overrun_count_1", ovr_pulses, 1);

    // Load and consume in the same cycle
    wait_cs_fall("f_ldcons", at);
    finish_frame("w_ldcons", at, 1'b0, 1'b1);
    tick(1);
    check("ldcons_consumed", sample_valid, 1'b0);

    // Offset-binary conversion words
    for (int i = 0; i < 2; i++) begin
      wait_cs_fall($sformatf("f_sgn%0d", i), at);
      finish_frame($sformatf("w_sgn%0d", i), at, 1'b0, 1'b0);
      check($sformatf("sgn%0d_const", i), sample_data,
            (i == 0) ? (SIGNED_BUILD ? 16'h0000 : 16'h8000)
                     : (SIGNED_BUILD ? 16'hFFFF : 16'h7FFF));
      tick(1);
    end

    // enable dropped during bit 7: frame still completes, then no new frame
    wait_cs_fall("f_endrop", at);
    tick(CD + 2 * CD * 7 + 2);
    enable = 1'b0;
    finish_frame("w_endrop", at, 1'b0, 1'b0);
    lows = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick(1);
      if (spi_chipselect !== 1'b1) lows++;
    end
    check("cs_high_while_disabled", lows, 0);
    en_at  = cyc;
    enable = 1'b1;
    wait_cs_fall("f_reen", at);
    check("reenable_latency", at - en_at, 1);
    finish_frame("w_reen", at, 1'b0, 1'b0);
    tick(1);

    // Reset in the LOW phase of bit 10
    wait_cs_fall("f_abort", at);
    tick(CD + 2 * CD * 10 + 2 - (cyc - at));
    check("pre_reset_sclk_low", spi_clock, 1'b0);
    reset = 1'b1;
    #2;
    check("async_rst_cs", spi_chipselect, 1'b1);
    check("async_rst_sclk", spi_clock, 1'b1);
    check("async_rst_valid", sample_valid, 1'b0);
    check("async_rst_data", sample_data, '0);
    exp_q.delete();
    tick(3);
    rel   = cyc;
    reset = 1'b0;
    wait_cs_fall("f_fresh", at);
    check("fresh_cs_cycle", at - rel, GAP);
    finish_frame("w_fresh", at, 1'b0, 1'b0);
    check("overrun_total", ovr_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
